// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - control/datapath bundle between mc_ctrl and the MIPS datapath
interface mc_ctrl_if #(
   parameter int ST_W = 3
);
   logic [5:0]      op;
   logic [5:0]      funct;
   logic            zero;
   logic            mem_rdy;
   logic            mem_req;
   logic            pc_wr;
   logic            ir_wr;
   logic            reg_wr;
   logic            dm_wr;
   logic [1:0]      alu_op;
   logic            alu_srcb;
   logic            ext_op;
   logic [1:0]      reg_dst;
   logic [1:0]      wd_sel;
   logic [1:0]      npc_sel;
   logic [ST_W-1:0] state;
   logic            retire;
   logic [31:0]     retire_cnt;

   modport master (
      input  op, funct, zero, mem_rdy,
      output mem_req, pc_wr, ir_wr, reg_wr, dm_wr, alu_op, alu_srcb, ext_op,
             reg_dst, wd_sel, npc_sel, state, retire, retire_cnt
   );

   modport slave (
      output op, funct, zero, mem_rdy,
      input  mem_req, pc_wr, ir_wr, reg_wr, dm_wr, alu_op, alu_srcb, ext_op,
             reg_dst, wd_sel, npc_sel, state, retire, retire_cnt
   );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM; RETIRE_CNT_EN adds a retired-instruction counter
module mc_ctrl #(
   parameter int ST_W = 3
) (
   input  logic     clk,
   input  logic     reset,
   mc_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXE    = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_BR     = 3'd5,
      S_JMP    = 3'd6,
      S_UNUSED = 3'd7
   } state_t;

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_ORI = 6'h0d;
   localparam logic [5:0] OP_LUI = 6'h0f;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2b;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUBU = 6'h23;

   state_t     cur, nxt;
   logic [5:0] op_q, funct_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cur     <= S_FETCH;
         op_q    <= '0;
         funct_q <= '0;
      end else begin
         cur <= nxt;
         if (cur == S_DECODE) begin
            op_q    <= bus.op;
            funct_q <= bus.funct;
         end
      end
   end

   always_comb begin
      nxt          = cur;
      bus.mem_req  = 1'b0;
      bus.pc_wr    = 1'b0;
      bus.ir_wr    = 1'b0;
      bus.reg_wr   = 1'b0;
      bus.dm_wr    = 1'b0;
      bus.alu_op   = 2'd0;
      bus.alu_srcb = 1'b0;
      bus.ext_op   = 1'b0;
      bus.reg_dst  = 2'd0;
      bus.wd_sel   = 2'd0;
      bus.npc_sel  = 2'd0;
      bus.retire   = 1'b0;
      bus.state    = ST_W'(cur);
      case (cur)
         S_FETCH: begin
            bus.mem_req = 1'b1;
            if (bus.mem_rdy) begin
               bus.ir_wr = 1'b1;
               bus.pc_wr = 1'b1;
               nxt       = S_DECODE;
            end
         end
         // IR was written at the end of FETCH, so decode the live opcode here.
         S_DECODE: begin
            if (bus.op == OP_R) begin
               if (bus.funct == F_ADDU || bus.funct == F_SUBU) begin
                  nxt = S_EXE;
               end else if (bus.funct == F_JR) begin
                  nxt = S_JMP;
               end else begin
                  nxt        = S_FETCH;
                  bus.retire = 1'b1;
               end
            end else begin
               case (bus.op)
                  OP_ORI, OP_LUI, OP_LW, OP_SW: nxt = S_EXE;
                  OP_BEQ:                       nxt = S_BR;
                  OP_J, OP_JAL:                 nxt = S_JMP;
                  default: begin
                     nxt        = S_FETCH;
                     bus.retire = 1'b1;
                  end
               endcase
            end
         end
         S_EXE: begin
            case (op_q)
               OP_ORI: begin
                  bus.alu_op   = 2'd2;
                  bus.alu_srcb = 1'b1;
               end
               OP_LUI: begin
                  bus.alu_op   = 2'd3;
                  bus.alu_srcb = 1'b1;
               end
               OP_LW, OP_SW: begin
                  bus.alu_srcb = 1'b1;
                  bus.ext_op   = 1'b1;
               end
               default: bus.alu_op = (funct_q == F_SUBU) ? 2'd1 : 2'd0;
            endcase
            nxt = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
         end
         S_MEM: begin
            bus.mem_req = 1'b1;
            bus.dm_wr   = (op_q == OP_SW);
            if (bus.mem_rdy) begin
               if (op_q == OP_SW) begin
                  nxt        = S_FETCH;
                  bus.retire = 1'b1;
               end else begin
                  nxt = S_WB;
               end
            end
         end
         S_WB: begin
            bus.reg_wr  = 1'b1;
            bus.reg_dst = (op_q == OP_R) ? 2'd1 : 2'd0;
            bus.wd_sel  = (op_q == OP_LW) ? 2'd1 : 2'd0;
            bus.retire  = 1'b1;
            nxt         = S_FETCH;
         end
         S_BR: begin
            bus.alu_op  = 2'd1;
            bus.ext_op  = 1'b1;
            bus.npc_sel = 2'd1;
            bus.pc_wr   = bus.zero;
            bus.retire  = 1'b1;
            nxt         = S_FETCH;
         end
         // jal links PC+4, which PC already holds since FETCH.
         S_JMP: begin
            bus.pc_wr = 1'b1;
            if (op_q == OP_R) begin
               bus.npc_sel = 2'd3;
            end else begin
               bus.npc_sel = 2'd2;
               if (op_q == OP_JAL) begin
                  bus.reg_wr  = 1'b1;
                  bus.reg_dst = 2'd2;
                  bus.wd_sel  = 2'd2;
               end
            end
            bus.retire = 1'b1;
            nxt        = S_FETCH;
         end
         default: nxt = S_FETCH;
      endcase
      if (!reset) begin
         bus.mem_req  = 1'b0;
         bus.pc_wr    = 1'b0;
         bus.ir_wr    = 1'b0;
         bus.reg_wr   = 1'b0;
         bus.dm_wr    = 1'b0;
         bus.alu_op   = 2'd0;
         bus.alu_srcb = 1'b0;
         bus.ext_op   = 1'b0;
         bus.reg_dst  = 2'd0;
         bus.wd_sel   = 2'd0;
         bus.npc_sel  = 2'd0;
         bus.retire   = 1'b0;
         bus.state    = '0;
      end
   end

`ifdef RETIRE_CNT_EN
   logic [31:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (bus.retire) begin
         cnt <= cnt + 32'd1;
      end
   end

   assign bus.retire_cnt = reset ? cnt : 32'h0;
`else
   assign bus.retire_cnt = 32'h0;
`endif
endmodule
